perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor.sv | 70 +++++++
 tb/tb_perf_monitor.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: run/freeze/clear event counters with sticky wrap flags and a registered readout.
// Define PERF_PC_WINDOW_EN to count only retirements whose PC lies in [i_win_lo, i_win_hi].
module perf_monitor #(
    parameter int CNT_W = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic [31:0] i_pc_debug,
    input  logic        i_ctrl,
    input  logic        i_mispred,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic [2:0]  i_rd_sel,
`ifdef PERF_PC_WINDOW_EN
    input  logic [31:0] i_win_lo,
    input  logic [31:0] i_win_hi,
`endif
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_state,
    output logic        o_ovf
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FROZEN = 2'b10} state_t;
    state_t state_q, state_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  ovf_q, ovf_d, ev;
    logic [31:0] pc_q, pc_d, rd_q, rd_d;
    logic        run, ret_ev;
`ifdef PERF_PC_WINDOW_EN
    assign ret_ev = i_insn_vld && i_pc_debug >= i_win_lo && i_pc_debug <= i_win_hi;
`else
    assign ret_ev = i_insn_vld;
`endif
    assign run = state_q == RUN && !i_clear;
    assign ev  = {i_mispred, i_ctrl, ret_ev, 1'b1};
    always_comb begin
        state_d = i_clear ? IDLE :
                  state_q == RUN ? (i_stop ? FROZEN : RUN) :
                  (i_start && !(i_stop && state_q == FROZEN)) ? RUN : state_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = i_clear ? '0 : cnt_q[k] + CNT_W'(run && ev[k]);
            ovf_d[k] = !i_clear && (ovf_q[k] || (run && ev[k] && &cnt_q[k]));
        end
        pc_d = i_clear ? 32'd0 : (run && ret_ev) ? i_pc_debug : pc_q;
        rd_d = !i_rd_sel[2] ? 32'(cnt_q[i_rd_sel[1:0]]) :
               i_rd_sel == 3'd4 ? pc_q :
               i_rd_sel == 3'd5 ? {28'd0, ovf_q} : 32'd0;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
        end
    end
    assign o_rd_data = rd_q;
    assign o_state   = state_q;
    assign o_ovf     = |ovf_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_perf_monitor;
    logic        clk = 0, rst = 1, insn = 0, ctrl = 0, mis = 0, start = 0, stop = 0, clear = 0;
    logic [31:0] pc = 0, rd_data;
    logic [2:0]  sel = 0;
    logic [1:0]  state;
    logic        ovf;
    int checks = 0, failures = 0;
    typedef struct {int kind; logic [31:0] exp; string name;} exp_t;
    exp_t q[$];
    logic iss = 0, iss_d = 0;
`ifdef PERF_PC_WINDOW_EN
    logic [31:0] win_lo = 32'h100, win_hi = 32'h1FF;
`endif

    perf_monitor #(.CNT_W(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_insn_vld(insn), .i_pc_debug(pc),
        .i_ctrl(ctrl), .i_mispred(mis), .i_start(start), .i_stop(stop),
        .i_clear(clear), .i_rd_sel(sel),
`ifdef PERF_PC_WINDOW_EN
        .i_win_lo(win_lo), .i_win_hi(win_hi),
`endif
        .o_rd_data(rd_data), .o_state(state), .o_ovf(ovf));

    always #5 clk = ~clk;

    always @(posedge clk) iss_d <= iss;

    always @(negedge clk) begin
        if (iss_d) begin
            exp_t e;
            logic [31:0] act;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                e = q.pop_front();
                act = e.kind == 0 ? rd_data : e.kind == 1 ? {30'd0, state} : {31'd0, ovf};
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic drv(input logic st, input logic sp, input logic cl, input logic iv,
                       input logic [31:0] p, input logic ct, input logic mp);
        @(posedge clk); #1;
        rst = 0; iss = 0; start = st; stop = sp; clear = cl; insn = iv; pc = p; ctrl = ct; mis = mp;
    endtask

    task automatic chk(input int kind, input logic [2:0] s, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk); #1;
        rst = 0; start = 0; stop = 0; clear = 0; insn = 0; ctrl = 0; mis = 0; pc = 0;
        sel = s; iss = 1;
        e.kind = kind; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 8; i++) chk(0, 3'(i), 32'd0, $sformatf("%s_sel%0d", tag, i));
        chk(1, 0, 32'd0, {tag, "_state"});
        chk(2, 0, 32'd0, {tag, "_ovf"});
    endtask

    initial begin
        rst = 1; insn = 1; start = 1;
        repeat (2) @(posedge clk);
        all_zero("reset");
        // 10 counted cycles, 7 retirements, stop on the last
        drv(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drv(0, i == 9, 0, i < 7, 32'h40 + 32'(4 * i), 0, 0);
        chk(0, 0, 32'd10, "run10_cycles");
        chk(0, 1, 32'd7, "run10_retired");
        chk(0, 4, 32'h58, "run10_last_pc");
        chk(0, 2, 32'd0, "run10_ctrl");
        chk(1, 0, 32'd2, "run10_frozen");
        // resume keeps counts; start while running is ignored
        drv(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drv(i == 1, i == 4, 0, 0, 0, 1, i < 3);
        chk(0, 2, 32'd5, "ctrl_count");
        chk(0, 3, 32'd3, "mispred_count");
        chk(0, 0, 32'd15, "resume_cycles");
        chk(0, 1, 32'd7, "resume_retired_kept");
        chk(1, 0, 32'd2, "resume_frozen");
        // start+stop in RUN freezes and that cycle counts
        drv(1, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        chk(1, 0, 32'd2, "startstop_frozen");
        chk(0, 0, 32'd16, "startstop_cycles");
        drv(1, 0, 1, 0, 0, 0, 0);
        all_zero("clear_start");
        drv(0, 1, 0, 0, 0, 0, 0);
        chk(1, 0, 32'd0, "idle_stop_ignored");
        // PC tracking
        drv(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h100, 0, 0);
        drv(0, 0, 0, 1, 32'h104, 0, 0);
        drv(0, 0, 0, 1, 32'h2000, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0);
`ifdef PERF_PC_WINDOW_EN
        chk(0, 1, 32'd2, "pc_retired");
        chk(0, 4, 32'h104, "pc_last");
`else
        chk(0, 1, 32'd3, "pc_retired");
        chk(0, 4, 32'h2000, "pc_last");
`endif
        chk(0, 0, 32'd4, "pc_cycles");
        // events in the clear cycle are dropped
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 1, 32'h999, 1, 1);
        all_zero("clear_discard");
        // 8-bit wrap
        drv(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 257; i++) drv(0, i == 256, 0, 0, 0, 0, 0);
        chk(0, 0, 32'd1, "wrap_cycles");
        chk(2, 0, 32'd1, "wrap_ovf");
        chk(0, 5, 32'd1, "wrap_flags");
        chk(0, 3, 32'd0, "wrap_mispred");
        chk(1, 0, 32'd2, "wrap_frozen");
        // reset mid-RUN overrides everything
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, 32'h300, 0, 0);
        @(posedge clk); #1;
        rst = 1; insn = 1; pc = 32'h304; start = 1; stop = 1; clear = 1; ctrl = 1; mis = 1;
        all_zero("midrun_reset");
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
